// File: rtl/vex_meta_pipe.sv
// Elastic metadata pipeline for the vector EX stage: carries dst/ticket/group
// markers/lane enables through STAGES registers with backpressure, flush and forwarding taps.
module vex_meta_pipe #(
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_LANES       = 8,
  parameter int VECTOR_TICKET_BITS = 5,
  parameter int STAGES             = 4,
  parameter int FWD_POINT_A        = 1,
  parameter int FWD_POINT_B        = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] dst_i,
  input  logic [VECTOR_TICKET_BITS-1:0]       ticket_i,
  input  logic                                head_i,
  input  logic                                end_i,
  input  logic [VECTOR_LANES-1:0]             lanes_i,
  input  logic                                flush_i,
  output logic                                frw_a_valid_o,
  output logic [$clog2(VECTOR_REGISTERS)-1:0] frw_a_addr_o,
  output logic [VECTOR_TICKET_BITS-1:0]       frw_a_ticket_o,
  output logic [VECTOR_LANES-1:0]             frw_a_lanes_o,
  output logic                                frw_b_valid_o,
  output logic [$clog2(VECTOR_REGISTERS)-1:0] frw_b_addr_o,
  output logic [VECTOR_TICKET_BITS-1:0]       frw_b_ticket_o,
  output logic [VECTOR_LANES-1:0]             frw_b_lanes_o,
  output logic                                wr_valid_o,
  input  logic                                wr_ready_i,
  output logic [$clog2(VECTOR_REGISTERS)-1:0] wr_addr_o,
  output logic [VECTOR_TICKET_BITS-1:0]       wr_ticket_o,
  output logic                                wr_head_o,
  output logic                                wr_end_o,
  output logic [VECTOR_LANES-1:0]             wr_lanes_o,
  output logic [$clog2(STAGES+1)-1:0]         inflight_o,
  output logic                                seq_err_o,
  output logic                                idle_o
);

  localparam int AW = $clog2(VECTOR_REGISTERS);
  localparam int TW = VECTOR_TICKET_BITS;
  localparam int LW = VECTOR_LANES;
  localparam int IW = $clog2(STAGES + 1);
  localparam int MW = AW + TW + 2 + LW;

  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $fatal(1, "vex_meta_pipe: STAGES must be in 1..16");
  end
  if (FWD_POINT_A < 0 || FWD_POINT_A > STAGES) begin : g_bad_fwd_a
    $fatal(1, "vex_meta_pipe: FWD_POINT_A must be in 0..STAGES");
  end
  if (FWD_POINT_B < 0 || FWD_POINT_B > STAGES) begin : g_bad_fwd_b
    $fatal(1, "vex_meta_pipe: FWD_POINT_B must be in 0..STAGES");
  end

  logic [STAGES:1] v_q, v_d, en;
  logic [MW-1:0]   meta_q [1:STAGES];
  logic [MW-1:0]   meta_d [1:STAGES];
  logic [MW-1:0]   in_meta;
  logic            accept, depart;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic            seq_err_q, seq_err_d;
  logic            open_q, open_d;

  // Meta word layout: {dst, ticket, head, end, lanes}
  assign in_meta = {dst_i, ticket_i, head_i, end_i, lanes_i};

  // A stage may advance if any stage at or after it is empty, or writeback drains.
  always_comb begin : p_enable
    logic hole;
    en   = '0;
    hole = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      hole  = hole | ~v_q[k];
      en[k] = hole | wr_ready_i;
    end
  end

  assign ready_o    = en[1] & ~flush_i & rst_n;
  assign accept     = valid_i & ready_o;
  assign wr_valid_o = v_q[STAGES] & rst_n;
  assign depart     = wr_valid_o & wr_ready_i;
  assign {wr_addr_o, wr_ticket_o, wr_head_o, wr_end_o, wr_lanes_o} = meta_q[STAGES];

  always_comb begin
    v_d = v_q;
    for (int k = 1; k <= STAGES; k++) meta_d[k] = meta_q[k];
    if (en[1]) begin
      v_d[1]    = accept;
      meta_d[1] = in_meta;
    end
    for (int k = 2; k <= STAGES; k++) begin
      if (en[k]) begin
        v_d[k]    = v_q[k-1];
        meta_d[k] = meta_q[k-1];
      end
    end
    if (flush_i) v_d = '0;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = '0;
    end else begin
      case ({accept, depart})
        2'b10:   inflight_d = inflight_q + 1'b1;
        2'b01:   inflight_d = inflight_q - 1'b1;
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // A head must arrive with the group closed; a non-head must arrive with it open.
  always_comb begin
    seq_err_d = seq_err_q;
    open_d    = open_q;
    if (accept) begin
      if (head_i == open_q) seq_err_d = 1'b1;
      if (end_i)            open_d    = 1'b0;
      else if (head_i)      open_d    = 1'b1;
    end
    if (flush_i) open_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q        <= '0;
      inflight_q <= '0;
      seq_err_q  <= 1'b0;
      open_q     <= 1'b0;
      for (int k = 1; k <= STAGES; k++) meta_q[k] <= '0;
    end else begin
      v_q        <= v_d;
      inflight_q <= inflight_d;
      seq_err_q  <= seq_err_d;
      open_q     <= open_d;
      for (int k = 1; k <= STAGES; k++) meta_q[k] <= meta_d[k];
    end
  end

  assign inflight_o = inflight_q;
  assign seq_err_o  = seq_err_q;
  assign idle_o     = ~valid_i & (inflight_q == '0);

  logic [1:0]    tap_v;
  logic [AW-1:0] tap_addr   [2];
  logic [TW-1:0] tap_ticket [2];
  logic [LW-1:0] tap_lanes  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_tap
    localparam int P = (gi == 0) ? FWD_POINT_A : FWD_POINT_B;
    if (P == 0) begin : g_input
      assign tap_v[gi]      = accept;
      assign tap_addr[gi]   = dst_i;
      assign tap_ticket[gi] = ticket_i;
      assign tap_lanes[gi]  = lanes_i;
    end else if (P <= STAGES) begin : g_stage
      assign tap_v[gi]      = v_q[P] & ~flush_i & rst_n;
      assign tap_addr[gi]   = meta_q[P][MW-1 -: AW];
      assign tap_ticket[gi] = meta_q[P][MW-AW-1 -: TW];
      assign tap_lanes[gi]  = meta_q[P][LW-1:0];
    end
  end

  assign frw_a_valid_o  = tap_v[0];
  assign frw_a_addr_o   = tap_addr[0];
  assign frw_a_ticket_o = tap_ticket[0];
  assign frw_a_lanes_o  = tap_lanes[0];
  assign frw_b_valid_o  = tap_v[1];
  assign frw_b_addr_o   = tap_addr[1];
  assign frw_b_ticket_o = tap_ticket[1];
  assign frw_b_lanes_o  = tap_lanes[1];

endmodule

// File: tb/tb_vex_meta_pipe.sv
// Directed bench for vex_meta_pipe: u0 uses default taps (1,3), u1 has tap A at the input side.
module tb_vex_meta_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, valid_i, head_i, end_i, flush_i, wr_ready_i;
  logic [4:0] dst_i, ticket_i;
  logic [7:0] lanes_i;

  logic       ready_o, frw_a_valid_o, frw_b_valid_o, wr_valid_o, wr_head_o, wr_end_o;
  logic       seq_err_o, idle_o;
  logic [4:0] frw_a_addr_o, frw_a_ticket_o, frw_b_addr_o, frw_b_ticket_o, wr_addr_o, wr_ticket_o;
  logic [7:0] frw_a_lanes_o, frw_b_lanes_o, wr_lanes_o;
  logic [2:0] inflight_o;

  logic       u1_ready_o, u1_frw_a_valid_o, u1_frw_b_valid_o, u1_wr_valid_o, u1_wr_head_o, u1_wr_end_o;
  logic       u1_seq_err_o, u1_idle_o;
  logic [4:0] u1_frw_a_addr_o, u1_frw_a_ticket_o, u1_frw_b_addr_o, u1_frw_b_ticket_o;
  logic [4:0] u1_wr_addr_o, u1_wr_ticket_o;
  logic [7:0] u1_frw_a_lanes_o, u1_frw_b_lanes_o, u1_wr_lanes_o;
  logic [2:0] u1_inflight_o;

  vex_meta_pipe u0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .dst_i(dst_i), .ticket_i(ticket_i), .head_i(head_i), .end_i(end_i),
    .lanes_i(lanes_i), .flush_i(flush_i),
    .frw_a_valid_o(frw_a_valid_o), .frw_a_addr_o(frw_a_addr_o),
    .frw_a_ticket_o(frw_a_ticket_o), .frw_a_lanes_o(frw_a_lanes_o),
    .frw_b_valid_o(frw_b_valid_o), .frw_b_addr_o(frw_b_addr_o),
    .frw_b_ticket_o(frw_b_ticket_o), .frw_b_lanes_o(frw_b_lanes_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .wr_ticket_o(wr_ticket_o), .wr_head_o(wr_head_o), .wr_end_o(wr_end_o),
    .wr_lanes_o(wr_lanes_o), .inflight_o(inflight_o), .seq_err_o(seq_err_o),
    .idle_o(idle_o)
  );

  vex_meta_pipe #(.FWD_POINT_A(0)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(u1_ready_o),
    .dst_i(dst_i), .ticket_i(ticket_i), .head_i(head_i), .end_i(end_i),
    .lanes_i(lanes_i), .flush_i(flush_i),
    .frw_a_valid_o(u1_frw_a_valid_o), .frw_a_addr_o(u1_frw_a_addr_o),
    .frw_a_ticket_o(u1_frw_a_ticket_o), .frw_a_lanes_o(u1_frw_a_lanes_o),
    .frw_b_valid_o(u1_frw_b_valid_o), .frw_b_addr_o(u1_frw_b_addr_o),
    .frw_b_ticket_o(u1_frw_b_ticket_o), .frw_b_lanes_o(u1_frw_b_lanes_o),
    .wr_valid_o(u1_wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(u1_wr_addr_o),
    .wr_ticket_o(u1_wr_ticket_o), .wr_head_o(u1_wr_head_o), .wr_end_o(u1_wr_end_o),
    .wr_lanes_o(u1_wr_lanes_o), .inflight_o(u1_inflight_o), .seq_err_o(u1_seq_err_o),
    .idle_o(u1_idle_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Inputs change at posedge+1; checks happen at posedge+3, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic v, input logic [4:0] d, input logic [4:0] t,
                       input logic h, input logic e);
    valid_i  = v;
    dst_i    = d;
    ticket_i = t;
    head_i   = h;
    end_i    = e;
    lanes_i  = {d[2:0], t};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sent;
    int got;
    logic acc;

    rst_n = 1'b0; flush_i = 1'b0; wr_ready_i = 1'b1;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); tick();

    // Reset state, with valid_i raised to show nothing is accepted under reset
    issue(1'b1, 5'd7, 5'd7, 1'b1, 1'b1);
    settle();
    check("rst_ready", ready_o, 0);
    check("rst_tap0_valid", u1_frw_a_valid_o, 0);
    check("rst_wr_valid", wr_valid_o, 0);
    check("rst_inflight", inflight_o, 0);
    check("rst_seq_err", seq_err_o, 0);
    tick();
    rst_n = 1'b1;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("rst_idle", idle_o, 1);
    check("rst_after_inflight", inflight_o, 0);
    tick();

    // Single uop latency through taps and writeback
    issue(1'b1, 5'd5, 5'd3, 1'b1, 1'b1);
    settle();
    check("lat_t0_ready", ready_o, 1);
    check("lat_t0_tap0_valid", u1_frw_a_valid_o, 1);
    check("lat_t0_tap0_addr", u1_frw_a_addr_o, 5);
    check("lat_t0_tapA_valid", frw_a_valid_o, 0);
    check("lat_t0_idle", idle_o, 0);
    tick();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("lat_t1_tapA_valid", frw_a_valid_o, 1);
    check("lat_t1_tapA_addr", frw_a_addr_o, 5);
    check("lat_t1_tapA_lanes", frw_a_lanes_o, 8'hA3);
    check("lat_t1_inflight", inflight_o, 1);
    check("lat_t1_idle", idle_o, 0);
    tick();
    settle();
    check("lat_t2_inflight", inflight_o, 1);
    check("lat_t2_tapB_valid", frw_b_valid_o, 0);
    check("lat_t2_wr_valid", wr_valid_o, 0);
    tick();
    settle();
    check("lat_t3_tapB_valid", frw_b_valid_o, 1);
    check("lat_t3_tapB_ticket", frw_b_ticket_o, 3);
    check("lat_t3_wr_valid", wr_valid_o, 0);
    tick();
    settle();
    check("lat_t4_wr_valid", wr_valid_o, 1);
    check("lat_t4_wr_addr", wr_addr_o, 5);
    check("lat_t4_wr_ticket", wr_ticket_o, 3);
    check("lat_t4_wr_head", wr_head_o, 1);
    check("lat_t4_wr_end", wr_end_o, 1);
    check("lat_t4_wr_lanes", wr_lanes_o, 8'hA3);
    check("lat_t4_inflight", inflight_o, 1);
    tick();
    settle();
    check("lat_t5_wr_valid", wr_valid_o, 0);
    check("lat_t5_inflight", inflight_o, 0);
    check("lat_t5_idle", idle_o, 1);
    tick();

    // Back-to-back issue, writeback stalls from cycle 2: four uops fill the pipe
    sent = 0;
    for (int t = 0; t < 6; t++) begin
      wr_ready_i = (t < 2);
      issue(1'b1, 5'(10 + sent), 5'(sent), 1'b1, 1'b1);
      settle();
      check($sformatf("b2b_ready_t%0d", t), ready_o, (t < 4) ? 1 : 0);
      check($sformatf("b2b_tap0_t%0d", t), u1_frw_a_valid_o, (t < 4) ? 1 : 0);
      if (t >= 4) begin
        check($sformatf("b2b_inflight_t%0d", t), inflight_o, 4);
        check($sformatf("b2b_wr_valid_t%0d", t), wr_valid_o, 1);
        check($sformatf("b2b_wr_addr_t%0d", t), wr_addr_o, 10);
        check($sformatf("b2b_wr_ticket_t%0d", t), wr_ticket_o, 0);
      end
      acc = valid_i & ready_o;
      tick();
      if (acc) sent++;
    end
    wr_ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      issue(sent < 6, 5'(10 + sent), 5'(sent), 1'b1, 1'b1);
      settle();
      if (c == 0) check("b2b_release_ready", ready_o, 1);
      if (wr_valid_o) begin
        check($sformatf("b2b_out%0d_addr", got), wr_addr_o, 10 + got);
        check($sformatf("b2b_out%0d_ticket", got), wr_ticket_o, got);
        got++;
      end
      acc = valid_i & ready_o;
      tick();
      if (acc) sent++;
    end
    check("b2b_out_count", got, 6);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("b2b_drained_inflight", inflight_o, 0);
    check("b2b_drained_wr_valid", wr_valid_o, 0);
    tick();

    // Bubble then stall: B collapses up to stage 3 behind A at stage 4
    wr_ready_i = 1'b0;
    issue(1'b1, 5'd20, 5'd1, 1'b1, 1'b1);
    settle(); check("bub_c0_ready", ready_o, 1); tick();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle(); check("bub_c1_ready", ready_o, 1); tick();
    issue(1'b1, 5'd21, 5'd2, 1'b1, 1'b1);
    settle(); check("bub_c2_ready", ready_o, 1); tick();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    settle();
    check("bub_c5_inflight", inflight_o, 2);
    check("bub_c5_ready", ready_o, 1);
    check("bub_c5_wr_addr", wr_addr_o, 20);
    check("bub_c5_tapB_valid", frw_b_valid_o, 1);
    check("bub_c5_tapB_addr", frw_b_addr_o, 21);
    check("bub_c5_tapA_valid", frw_a_valid_o, 0);
    tick();
    wr_ready_i = 1'b1;
    settle();
    check("bub_c6_wr_valid", wr_valid_o, 1);
    check("bub_c6_wr_addr", wr_addr_o, 20);
    tick();
    settle();
    check("bub_c7_wr_valid", wr_valid_o, 1);
    check("bub_c7_wr_addr", wr_addr_o, 21);
    tick();
    settle();
    check("bub_c8_wr_valid", wr_valid_o, 0);
    check("bub_c8_inflight", inflight_o, 0);
    tick();

    // Flush with three in flight while the oldest completes writeback
    issue(1'b1, 5'd1, 5'd1, 1'b1, 1'b1); tick();
    issue(1'b1, 5'd2, 5'd2, 1'b1, 1'b1); tick();
    issue(1'b1, 5'd3, 5'd3, 1'b1, 1'b1); tick();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    flush_i = 1'b1;
    issue(1'b1, 5'd9, 5'd9, 1'b1, 1'b1);
    settle();
    check("fl_inflight_before", inflight_o, 3);
    check("fl_ready", ready_o, 0);
    check("fl_tap0_valid", u1_frw_a_valid_o, 0);
    check("fl_tapB_valid", frw_b_valid_o, 0);
    check("fl_wr_valid", wr_valid_o, 1);
    check("fl_wr_addr", wr_addr_o, 1);
    tick();
    flush_i = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("fl_after_inflight", inflight_o, 0);
    check("fl_after_wr_valid", wr_valid_o, 0);
    check("fl_after_tapA_valid", frw_a_valid_o, 0);
    check("fl_after_tapB_valid", frw_b_valid_o, 0);
    check("fl_after_idle", idle_o, 1);
    tick(); tick(); tick();
    settle();
    check("fl_late_wr_valid", wr_valid_o, 0);
    tick();

    // Group protocol: legal three-uop group, then an orphan non-head uop
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd2, 5'd0, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd0, 1'b0, 1'b1); tick();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("grp_legal_seq_err", seq_err_o, 0);
    tick();
    issue(1'b1, 5'd4, 5'd0, 1'b0, 1'b0);
    settle();
    check("grp_pre_err_seq_err", seq_err_o, 0);
    tick();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("grp_orphan_seq_err", seq_err_o, 1);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    settle();
    check("grp_flush_seq_err", seq_err_o, 1);
    check("grp_flush_inflight", inflight_o, 0);
    tick();

    // Reset asserted mid-stream
    issue(1'b1, 5'd6, 5'd1, 1'b1, 1'b1); tick();
    issue(1'b1, 5'd7, 5'd2, 1'b1, 1'b1); tick();
    rst_n = 1'b0;
    issue(1'b1, 5'd8, 5'd3, 1'b1, 1'b1);
    settle();
    check("mrst_ready", ready_o, 0);
    check("mrst_tap0_valid", u1_frw_a_valid_o, 0);
    check("mrst_tapA_valid", frw_a_valid_o, 0);
    check("mrst_inflight_before", inflight_o, 2);
    tick();
    rst_n = 1'b1;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    check("mrst_inflight", inflight_o, 0);
    check("mrst_seq_err", seq_err_o, 0);
    check("mrst_tapA_after", frw_a_valid_o, 0);
    check("mrst_tapB_after", frw_b_valid_o, 0);
    tick(); tick();
    settle();
    check("mrst_wr_valid", wr_valid_o, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
